stage_sequencer: RTL and testbench
==================================

Name: stage_sequencer

Overview:
- Controller that sequences a one-hot stage clock generator by driving its sc_start/sc_shift inputs.
- Accepts a run request (pass count, per-stage dwell); per pass: one start pulse, then NUM_STAGES-1 shift pulses, each stage held for a programmable dwell.
- Observes the generator's stage vector to detect sequencing faults.
- Sits between the control/register interface and the stage clock generator.

Parameters:
NUM_STAGES, 6, stages in the generator (width of sc_out)
PASS_W, 8, width of pass count
DWELL_W, 4, width of per-stage dwell count

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  run request valid
req_ready  out  1  high only in IDLE; accept = req_valid & req_ready
req_passes  in  PASS_W  number of full passes to run
req_dwell  in  DWELL_W  extra hold cycles per stage
abort  in  1  abandon run / clear error
sc_start  out  1  to generator: load stage 0 at next edge
sc_shift  out  1  to generator: advance one stage at next edge
sc_out  in  NUM_STAGES  generator's current one-hot stage vector
busy  out  1  high in START, DWELL, SHIFT
done  out  1  one-cycle pulse when all passes complete
err  out  1  sticky one-hot/sequence mismatch flag
cur_stage  out  $clog2(NUM_STAGES)  stage index being held
pass_cnt  out  PASS_W  completed passes in current run

Behaviour:
- Reset: state=IDLE; req_ready=1 (combinational from IDLE, abort has no effect on it); sc_start=sc_shift=busy=done=err=0; cur_stage=0; pass_cnt=0; dwell counter=0.
- States: IDLE, START, DWELL, SHIFT, DONE, ERR.
- IDLE: on accept, latch req_passes and req_dwell, clear pass_cnt. If passes==0, go to DONE; otherwise go to START.
- START (1 cycle): sc_start=1, cur_stage=0 -> DWELL.
- DWELL (D+1 cycles, D = latched dwell):
  - First cycle: check sc_out == (1<<cur_stage); mismatch -> ERR.
  - When the dwell counter reaches D: if cur_stage<NUM_STAGES-1, go to SHIFT.
  - Otherwise pass_cnt++ and go to DONE if pass_cnt+1==passes, else START.
- SHIFT (1 cycle): sc_shift=1, cur_stage++ -> DWELL.
- DONE (1 cycle): done=1 -> IDLE.
- ERR: err=1, busy=0, req_ready=0, sc_start=sc_shift=0; held until abort or rst. Abort -> IDLE and clears err.
- Generator outputs: sc_start and sc_shift are registered (Moore from state) and never high together.
- Timing: per-pass length = NUM_STAGES*(D+2) cycles. With accept at cycle 0, done is high at cycle 1 + P*NUM_STAGES*(D+2).
- Abort: in any non-IDLE state, next state is IDLE; pass_cnt is held and sc_start/sc_shift are deasserted the same cycle. No done pulse.
- Abort with req_valid in IDLE: no accept in that cycle.
- Request handling: req_valid outside IDLE is ignored (req_ready=0). Back-to-back requests are accepted on the cycle after DONE.
- Widths: pass_cnt wraps at 2^PASS_W (unreachable, since passes<2^PASS_W). cur_stage never exceeds NUM_STAGES-1.
- rst mid-run: all state returns to reset values at the next edge.

Optional Feature:
- STAGE_CHECK_EN defined: DWELL-entry one-hot check and ERR state are active.
- STAGE_CHECK_EN undefined: sc_out is ignored, err is tied 0, and the ERR state is unreachable/omitted.

Decomposition:
- Package stage_seq_pkg holds:
  - state enum stage_seq_state_t
  - default NUM_STAGES localparam
  - function onehot_stage(idx) returning the expected sc_out vector
- One natural sub-module, stage_seq_dwell_timer:
  - load/enable, DWELL_W counter
  - expire pulse when count==D

Test Plan:
1. Reset behaviour: rst=1 for 2 cycles -> req_ready=1, all other outputs 0, cur_stage=0, pass_cnt=0.
2. Single pass, D=0 (bench stage-clock model attached): passes=1, dwell=0, accepted at cycle 0 -> sc_start at cycle 1, sc_shift at cycles 3,5,7,9,11, done at cycle 13, pass_cnt=1, err=0.
3. Multi-pass with dwell: passes=2, dwell=3 -> each stage held 4 cycles, done at cycle 61, sc_start pulses at cycles 1 and 31.
4. Zero passes: passes=0 -> done at cycle 1, sc_start/sc_shift never asserted, busy stays 0.
5. Abort mid-run: abort during the 3rd SHIFT -> next cycle IDLE, req_ready=1, no done, pass_cnt=0. A new request is accepted normally afterwards.
6. Fault detection (STAGE_CHECK_EN): force sc_out=6'b000011 after the first shift -> ERR next cycle, err=1 sticky, req_ready=0. Abort -> IDLE, err=0. Without the macro: err stays 0 and done arrives on schedule.

Source files
------------

// File: rtl/stage_seq_pkg.sv
// stage_seq_pkg: shared types and helpers for the stage sequencer.
//   - stage_seq_state_t : sequencer state encoding
//   - STAGE_SEQ_NUM_STAGES : default number of generator stages
//   - onehot_stage(idx) : expected generator stage vector for stage idx
package stage_seq_pkg;

  localparam int unsigned STAGE_SEQ_NUM_STAGES = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DWELL = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } stage_seq_state_t;

  // Returned 32 bits wide; callers truncate to their own stage count.
  function automatic logic [31:0] onehot_stage(input logic [4:0] idx);
    onehot_stage = 32'd1 << idx;
  endfunction

endpackage

// File: rtl/stage_seq_dwell_timer.sv
// stage_seq_dwell_timer: per-stage hold counter.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load       : clear the counter (held while not dwelling)
//   en         : counting enabled (sequencer is in DWELL)
//   dwell      : terminal count D; the stage is held D+1 cycles
//   first      : high in the first dwell cycle (count==0)
//   expire     : high in the last dwell cycle (count==D)
module stage_seq_dwell_timer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  output logic               first,
  output logic               expire
);

  logic [DWELL_W-1:0] count_r;

  assign first  = en & (count_r == {DWELL_W{1'b0}});
  assign expire = en & (count_r == dwell);

  // Dwell counter: cleared outside DWELL, stops at the terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {DWELL_W{1'b0}};
    end else if (load) begin
      count_r <= {DWELL_W{1'b0}};
    end else if (en && !expire) begin
      count_r <= count_r + {{(DWELL_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: drives sc_start/sc_shift of a one-hot stage clock
// generator for a requested number of passes, holding each stage for a
// programmable dwell, and optionally watches sc_out for sequencing faults.
// Build option: define STAGE_CHECK_EN to enable the DWELL-entry one-hot
// check and the sticky ERR state; otherwise sc_out is ignored and err=0.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : run request handshake (ready only in IDLE)
//   req_passes, req_dwell : pass count and extra hold cycles per stage
//   abort                 : abandon the run / clear an error
//   sc_start, sc_shift    : registered strobes to the generator
//   sc_out                : generator's current one-hot stage vector
//   busy, done, err       : status (done is a one-cycle pulse)
//   cur_stage, pass_cnt   : stage being held, completed passes
module stage_sequencer
  import stage_seq_pkg::*;
#(
  parameter int NUM_STAGES = STAGE_SEQ_NUM_STAGES,
  parameter int PASS_W     = 8,
  parameter int DWELL_W    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [PASS_W-1:0]             req_passes,
  input  logic [DWELL_W-1:0]            req_dwell,
  input  logic                          abort,
  output logic                          sc_start,
  output logic                          sc_shift,
  input  logic [NUM_STAGES-1:0]         sc_out,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [$clog2(NUM_STAGES)-1:0] cur_stage,
  output logic [PASS_W-1:0]             pass_cnt
);

  localparam int SW = $clog2(NUM_STAGES);
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_START = ST_START;
  localparam logic [2:0] S_DWELL = ST_DWELL;
  localparam logic [2:0] S_SHIFT = ST_SHIFT;
  localparam logic [2:0] S_DONE  = ST_DONE;
`ifdef STAGE_CHECK_EN
  localparam logic [2:0] S_ERR   = ST_ERR;
`endif

  logic [2:0]         state_r, next_s;
  logic [PASS_W-1:0]  passes_r, pass_cnt_r;
  logic [DWELL_W-1:0] dwell_r;
  logic [SW-1:0]      cur_stage_r;
  logic               req_ready_r, sc_start_r, sc_shift_r, busy_r, done_r, err_r;
  logic               accept_s, first_s, expire_s, stage_bad_s, last_pass_s;

  assign accept_s    = (state_r == S_IDLE) && req_valid && !abort;
  assign last_pass_s = ((pass_cnt_r + {{(PASS_W-1){1'b0}}, 1'b1}) == passes_r);

  stage_seq_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (state_r != S_DWELL),
    .en     (state_r == S_DWELL),
    .dwell  (dwell_r),
    .first  (first_s),
    .expire (expire_s)
  );

`ifdef STAGE_CHECK_EN
  assign stage_bad_s = first_s &&
                       (sc_out != NUM_STAGES'(onehot_stage(5'(cur_stage_r))));
`else
  logic unused_ok_s;
  assign unused_ok_s = ^{sc_out, first_s};
  assign stage_bad_s = 1'b0;
`endif

  // Next-state logic; abort overrides everything outside IDLE.
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          next_s = (req_passes == {PASS_W{1'b0}}) ? S_DONE : S_START;
        end else begin
          next_s = S_IDLE;
        end
      end
      S_START: next_s = S_DWELL;
      S_DWELL: begin
`ifdef STAGE_CHECK_EN
        if (stage_bad_s) begin
          next_s = S_ERR;
        end else
`endif
        if (expire_s) begin
          if (cur_stage_r != LAST_STAGE) begin
            next_s = S_SHIFT;
          end else begin
            next_s = last_pass_s ? S_DONE : S_START;
          end
        end else begin
          next_s = S_DWELL;
        end
      end
      S_SHIFT: next_s = S_DWELL;
      S_DONE:  next_s = S_IDLE;
`ifdef STAGE_CHECK_EN
      S_ERR:   next_s = S_ERR;
`endif
      default: next_s = S_IDLE;
    endcase
    if (abort && (state_r != S_IDLE)) begin
      next_s = S_IDLE;
    end else begin
      next_s = next_s;
    end
  end

  // State, run context and Moore outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      passes_r    <= {PASS_W{1'b0}};
      dwell_r     <= {DWELL_W{1'b0}};
      pass_cnt_r  <= {PASS_W{1'b0}};
      cur_stage_r <= {SW{1'b0}};
      req_ready_r <= 1'b1;
      sc_start_r  <= 1'b0;
      sc_shift_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= next_s;
      req_ready_r <= (next_s == S_IDLE);
      sc_start_r  <= (next_s == S_START);
      sc_shift_r  <= (next_s == S_SHIFT);
      busy_r      <= (next_s == S_START) || (next_s == S_DWELL) || (next_s == S_SHIFT);
      done_r      <= (next_s == S_DONE);
`ifdef STAGE_CHECK_EN
      err_r       <= (next_s == S_ERR);
`else
      err_r       <= 1'b0;
`endif
      if (accept_s) begin
        passes_r   <= req_passes;
        dwell_r    <= req_dwell;
        pass_cnt_r <= {PASS_W{1'b0}};
      end else if ((state_r == S_DWELL) && expire_s && !stage_bad_s && !abort &&
                   (cur_stage_r == LAST_STAGE)) begin
        pass_cnt_r <= pass_cnt_r + {{(PASS_W-1){1'b0}}, 1'b1};
      end else begin
        pass_cnt_r <= pass_cnt_r;
      end
      // Stage index advances only when a shift really completes.
      if (accept_s || (next_s == S_START)) begin
        cur_stage_r <= {SW{1'b0}};
      end else if ((state_r == S_SHIFT) && (next_s == S_DWELL)) begin
        cur_stage_r <= cur_stage_r + {{(SW-1){1'b0}}, 1'b1};
      end else begin
        cur_stage_r <= cur_stage_r;
      end
    end
  end

  assign req_ready = req_ready_r;
  assign sc_start  = sc_start_r;
  assign sc_shift  = sc_shift_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign cur_stage = cur_stage_r;
  assign pass_cnt  = pass_cnt_r;

endmodule

// File: tb/tb_stage_sequencer.sv
module tb_stage_sequencer;

  logic       clk = 1'b0;
  logic       rst, req_valid, abort, req_ready, sc_start, sc_shift, busy, done, err;
  logic [7:0] req_passes, pass_cnt;
  logic [3:0] req_dwell;
  logic [5:0] sc_out, gen_r;
  logic [2:0] cur_stage;
  logic       fault_mode;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stage_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_passes(req_passes), .req_dwell(req_dwell), .abort(abort),
    .sc_start(sc_start), .sc_shift(sc_shift), .sc_out(sc_out),
    .busy(busy), .done(done), .err(err), .cur_stage(cur_stage), .pass_cnt(pass_cnt)
  );

  // Behavioural stage clock generator.
  always @(posedge clk) begin
    if (rst)           gen_r <= 6'b000000;
    else if (sc_start) gen_r <= 6'b000001;
    else if (sc_shift) gen_r <= {gen_r[4:0], gen_r[5]};
    else               gen_r <= gen_r;
  end
  // Fault injection corrupts stage 1's vector.
  assign sc_out = (fault_mode && gen_r == 6'b000010) ? 6'b000011 : gen_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int done_cyc, pass_at_done, n_start, n_shift, last_start, first_shift;
    int busy_seen, both_seen, ready_busy, max_stage, ready0, err_seen;
  } obs_t;

  typedef struct {
    logic [7:0] passes;
    logic [3:0] dwell;
    int exp_done, exp_pass, exp_starts, exp_shifts, exp_last_start, exp_first_shift;
    int exp_busy, exp_max_stage;
  } vec_t;

  // Issue a request in the current cycle (cycle 0) and observe until done.
  task automatic run_req(input logic [7:0] p, input logic [3:0] d, input int budget, output obs_t o);
    o = '{default: 0};
    o.done_cyc = -1;
    @(posedge clk); #1;
    o.ready0   = req_ready;
    req_passes = p;
    req_dwell  = d;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (sc_start) begin o.n_start++; o.last_start = k; end
      if (sc_shift) begin o.n_shift++; if (o.first_shift == 0) o.first_shift = k; end
      if (busy) o.busy_seen = 1;
      if (sc_start && sc_shift) o.both_seen++;
      if (busy && req_ready) o.ready_busy++;
      if (err) o.err_seen = 1;
      if (int'(cur_stage) > o.max_stage) o.max_stage = int'(cur_stage);
      if (done) begin
        o.done_cyc = k;
        o.pass_at_done = int'(pass_cnt);
        break;
      end
    end
  endtask

  vec_t vecs[5];
  obs_t o;
  int   shifts_seen;

  initial begin
    vecs[0] = '{8'd1, 4'd0,  13,  1, 1,  5,  1,  3, 1, 5};
    vecs[1] = '{8'd2, 4'd3,  61,  2, 2, 10, 31,  6, 1, 5};
    vecs[2] = '{8'd0, 4'd5,   1,  0, 0,  0,  0,  0, 0, 0};
    vecs[3] = '{8'd3, 4'd1,  55,  3, 3, 15, 37,  4, 1, 5};
    vecs[4] = '{8'd1, 4'd15, 103, 1, 1,  5,  1, 18, 1, 5};

    rst = 1'b1; req_valid = 1'b0; abort = 1'b0; fault_mode = 1'b0;
    req_passes = 8'd0; req_dwell = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 1); check("rst_start", sc_start, 0);
    check("rst_shift", sc_shift, 0);  check("rst_busy", busy, 0);
    check("rst_done", done, 0);       check("rst_err", err, 0);
    check("rst_stage", cur_stage, 0); check("rst_pass", pass_cnt, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_req(vecs[i].passes, vecs[i].dwell, 300, o);
      check($sformatf("v%0d_ready0", i), o.ready0, 1);
      check($sformatf("v%0d_done_cyc", i), o.done_cyc, vecs[i].exp_done);
      check($sformatf("v%0d_pass_cnt", i), o.pass_at_done, vecs[i].exp_pass);
      check($sformatf("v%0d_starts", i), o.n_start, vecs[i].exp_starts);
      check($sformatf("v%0d_shifts", i), o.n_shift, vecs[i].exp_shifts);
      check($sformatf("v%0d_last_start", i), o.last_start, vecs[i].exp_last_start);
      check($sformatf("v%0d_first_shift", i), o.first_shift, vecs[i].exp_first_shift);
      check($sformatf("v%0d_busy", i), o.busy_seen, vecs[i].exp_busy);
      check($sformatf("v%0d_max_stage", i), o.max_stage, vecs[i].exp_max_stage);
      check($sformatf("v%0d_both", i), o.both_seen, 0);
      check($sformatf("v%0d_ready_busy", i), o.ready_busy, 0);
      check($sformatf("v%0d_err", i), o.err_seen, 0);
      @(negedge clk);
      check($sformatf("v%0d_post_ready", i), req_ready, 1);
      check($sformatf("v%0d_post_done", i), done, 0);
    end

    // Abort with req_valid in IDLE: no accept.
    @(posedge clk); #1;
    req_passes = 8'd1; req_dwell = 4'd0; req_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("idle_abort_ready", req_ready, 1);
    check("idle_abort_busy", busy, 0);
    check("idle_abort_start", sc_start, 0);

    // Abort during the third SHIFT.
    @(posedge clk); #1;
    req_passes = 8'd2; req_dwell = 4'd1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    shifts_seen = 0;
    for (int k = 0; k < 100 && shifts_seen < 3; k++) begin
      @(negedge clk);
      if (sc_shift) shifts_seen++;
    end
    check("abort_reached_shift3", shifts_seen, 3);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_ready", req_ready, 1); check("abort_busy", busy, 0);
    check("abort_shift", sc_shift, 0);  check("abort_start", sc_start, 0);
    check("abort_pass", pass_cnt, 0);
    o.done_cyc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) o.done_cyc++;
    end
    check("abort_no_done", o.done_cyc, 0);
    run_req(8'd1, 4'd0, 100, o);
    check("after_abort_done_cyc", o.done_cyc, 13);
    check("after_abort_pass", o.pass_at_done, 1);

    // Synchronous reset in the middle of a run.
    run_req(8'd3, 4'd2, 7, o);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", req_ready, 1); check("midrst_busy", busy, 0);
    check("midrst_stage", cur_stage, 0); check("midrst_pass", pass_cnt, 0);

    // Corrupted stage vector after the first shift.
    fault_mode = 1'b1;
`ifdef STAGE_CHECK_EN
    run_req(8'd1, 4'd2, 6, o);
    check("fault_err_pre", err, 0);
    @(negedge clk);
    check("fault_err", err, 1);
    check("fault_ready", req_ready, 0);
    check("fault_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("fault_err_sticky", err, 1);
    check("fault_no_done", done, 0);
    check("fault_no_shift", sc_shift, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("fault_abort_err", err, 0);
    check("fault_abort_ready", req_ready, 1);
`else
    run_req(8'd1, 4'd2, 100, o);
    check("nofault_done_cyc", o.done_cyc, 25);
    check("nofault_err", o.err_seen, 0);
    check("nofault_pass", o.pass_at_done, 1);
`endif
    fault_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
